// File: rtl/uart_tx_serializer.sv
// UART transmitter: synchronizes an external baud clock into one-cycle ticks and
// shifts a latched word out LSB first with optional parity and 1-2 stop bits.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_in,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int            CW           = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] LP_LAST_BIT  = CW'(DATA_BITS);
   localparam logic [1:0]    LP_STOP_LAST = 2'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state,    w_state_nxt;
   logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
   logic [CW-1:0]        r_cnt,      w_cnt_nxt;
   logic [1:0]           r_stop_cnt, w_stop_cnt_nxt;
   logic                 r_parity,   w_parity_nxt;
   logic                 r_tx,       w_tx_nxt;
   logic                 r_busy,     w_busy_nxt;
   logic                 r_done,     w_done_nxt;
   logic                 r_sync1, r_sync2, r_sync3;
   logic                 w_tick;

   // baud_in is asynchronous; only its synchronized rising edge is used
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= baud_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_tick = r_sync2 & ~r_sync3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_stop_cnt <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_cnt      <= w_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_parity   <= w_parity_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_cnt_nxt      = r_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_parity_nxt   = r_parity;
      w_tx_nxt       = r_tx;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (tx_start) begin
               w_shift_nxt    = tx_data;
               w_cnt_nxt      = '0;
               w_stop_cnt_nxt = '0;
               w_parity_nxt   = (^tx_data) ^ 1'(PARITY_ODD);
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_WAIT;
            end
         end
         // a tick coinciding with acceptance is skipped so the start bit is full length
         S_WAIT: begin
            if (w_tick) begin
               w_tx_nxt    = 1'b0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
               w_cnt_nxt   = CW'(1);
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_cnt < LP_LAST_BIT) begin
                  w_tx_nxt    = r_shift[0];
                  w_shift_nxt = r_shift >> 1;
                  w_cnt_nxt   = r_cnt + CW'(1);
               end else if (PARITY_EN != 0) begin
                  w_tx_nxt    = r_parity;
                  w_state_nxt = S_PARITY;
               end else begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_tx_nxt    = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_tick) begin
               if (r_stop_cnt == LP_STOP_LAST) begin
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_stop_cnt_nxt = r_stop_cnt + 2'd1;
               end
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule
